// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP data-memory stage: MMIO control/status
// address, status bit positions, host-port FSM states and the host read-data
// source selector.
package asip_pkg;
  localparam logic [31:0] CTRL_A  = 32'hFFFF_FFF0;
  localparam int          ST_RUN  = 0;
  localparam int          ST_DONE = 1;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_WAIT  = 2'd1,
    H_GRANT = 2'd2
  } host_state_t;

  // Where host_rdata comes from after a host read.
  localparam logic [1:0] HSRC_ZERO = 2'd0;
  localparam logic [1:0] HSRC_RAM  = 2'd1;
  localparam logic [1:0] HSRC_STAT = 2'd2;
endpackage

// File: rtl/dmem_ram.sv
// Word RAM for the data-memory stage.
//  clock/reset : clock, synchronous active-low reset (clears hrdata only)
//  we/waddr/wdata : single synchronous write port
//  raddr/rdata    : asynchronous read port (CPU load path)
//  hre/haddr/hrdata : registered read port (host path)
// RAM contents are never cleared.
module dmem_ram #(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata,
  input  logic          hre,
  input  logic [AW-1:0] haddr,
  output logic [N-1:0]  hrdata
);
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clock) begin
    if (!reset)   hrdata <= '0;
    else if (hre) hrdata <= mem[haddr];
  end
endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: CPU word RAM (combinational load, synchronous store),
// host load/unload port arbitrated behind the CPU, and an MMIO control/status
// word (bit0 cpu_run, bit1 done) at CTRL_A.
//  clock, reset            : clock, synchronous active-low reset
//  cpu_addr/wdata/we/re    : MEM-stage access; cpu_rdata combinational
//  host_req/we/addr/wdata  : host request, held until host_ack
//  host_ack/host_rdata     : one-cycle completion pulse, read data with it
//  cpu_run, done, err      : start bit, completion flag, sticky access error
module data_mem_unit #(
  parameter int          N      = 32,
  parameter int          DEPTH  = 1024,
  parameter int          ADDR_W = 10,
  parameter logic [N-1:0] CTRL_A = asip_pkg::CTRL_A
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  input  logic         cpu_we,
  input  logic         cpu_re,
  output logic [N-1:0] cpu_rdata,
  input  logic         host_req,
  input  logic         host_we,
  input  logic [N-1:0] host_addr,
  input  logic [N-1:0] host_wdata,
  output logic         host_ack,
  output logic [N-1:0] host_rdata,
  output logic         cpu_run,
  output logic         done,
  output logic         err
);
  import asip_pkg::*;

  host_state_t state, nxt;
  logic [N-1:0] status, ram_rd, ram_hq, ram_wdata;
  logic [ADDR_W-1:0] c_idx, h_idx, ram_waddr;
  logic c_ctrl, c_ok, c_bad, c_acc, c_idle;
  logic h_ctrl, h_ok, h_bad, host_go, ram_we;
  logic [1:0] hsrc, hstat;

  // Address decode: CTRL_A is MMIO; anything else must be aligned and in range.
  assign c_idx  = cpu_addr[ADDR_W+1:2];
  assign c_ctrl = (cpu_addr == CTRL_A);
  assign c_bad  = !c_ctrl && ((cpu_addr[1:0] != 2'b00) || (|cpu_addr[N-1:ADDR_W+2]));
  assign c_ok   = !c_ctrl && !c_bad;
  assign c_acc  = cpu_we || cpu_re;
  assign c_idle = !c_acc;

  assign h_idx  = host_addr[ADDR_W+1:2];
  assign h_ctrl = (host_addr == CTRL_A);
  assign h_bad  = !h_ctrl && ((host_addr[1:0] != 2'b00) || (|host_addr[N-1:ADDR_W+2]));
  assign h_ok   = !h_ctrl && !h_bad;

  always_comb begin
    status          = '0;
    status[ST_RUN]  = cpu_run;
    status[ST_DONE] = done;
  end

  // The host access itself happens on the edge that enters GRANT, a cycle in
  // which the CPU is idle, so the single write port is never contended and
  // host_rdata is already valid while GRANT raises host_ack.
  assign host_go = reset && host_req && c_idle && (state != H_GRANT);

  always_comb begin
    nxt = state;
    case (state)
      H_IDLE:  if (host_req) nxt = c_idle ? H_GRANT : H_WAIT;
      H_WAIT:  if (c_idle)   nxt = H_GRANT;
      H_GRANT: nxt = H_IDLE;
      default: nxt = H_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= H_IDLE;
    else        state <= nxt;
  end

  assign host_ack = (state == H_GRANT);

  assign ram_we    = host_go ? (host_we && h_ok) : (cpu_we && c_ok);
  assign ram_waddr = host_go ? h_idx : c_idx;
  assign ram_wdata = host_go ? host_wdata : cpu_wdata;

  dmem_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
    .clock  (clock),
    .reset  (reset),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (c_idx),
    .rdata  (ram_rd),
    .hre    (host_go && !host_we && h_ok),
    .haddr  (h_idx),
    .hrdata (ram_hq)
  );

  assign cpu_rdata = c_ctrl ? status : (c_ok ? ram_rd : '0);

  // Remember what the last host read targeted; status is snapshotted at access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hsrc  <= HSRC_ZERO;
      hstat <= 2'b00;
    end else if (host_go && !host_we) begin
      hsrc  <= h_ctrl ? HSRC_STAT : (h_ok ? HSRC_RAM : HSRC_ZERO);
      hstat <= {done, cpu_run};
    end
  end

  always_comb begin
    host_rdata = '0;
    case (hsrc)
      HSRC_RAM:  host_rdata = ram_hq;
      HSRC_STAT: begin
        host_rdata[ST_RUN]  = hstat[0];
        host_rdata[ST_DONE] = hstat[1];
      end
      default:   host_rdata = '0;
    endcase
  end

  // CPU and host CTRL_A writes are mutually exclusive (host_go needs an idle CPU).
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_run <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (cpu_we && c_ctrl && cpu_wdata[ST_DONE]) begin
        done    <= 1'b1;
        cpu_run <= 1'b0;
      end
      if (host_go && host_we && h_ctrl) begin
        if (host_wdata[ST_RUN]) begin
          cpu_run <= 1'b1;
          done    <= 1'b0;
        end
        if (host_wdata[ST_DONE]) done <= 1'b0;
      end
      if ((c_acc && c_bad) || (host_go && h_bad)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a driver applies directed and random
// CPU/host traffic, updates a word-level reference model and queues expected
// responses; a negedge monitor pops and compares whenever the DUT responds.
module tb_data_mem_unit;
  localparam int DEPTH = 1024;
  localparam logic [31:0] CTRL = 32'hFFFF_FFF0;

  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_we = 1'b0, cpu_re = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0, host_ack;
  logic [31:0] host_addr = '0, host_wdata = '0, host_rdata;
  logic        cpu_run, done, err;

  always #5 clock = ~clock;

  data_mem_unit dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .cpu_run(cpu_run), .done(done), .err(err)
  );

  int total = 0, bad = 0, cyc = 0;
  bit mon_en = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; bit chk; logic [31:0] rd; } hexp_t;
  typedef struct { bit chk; logic [31:0] v; } cexp_t;
  hexp_t hq[$];
  cexp_t cq[$];

  // Reference model: memory by word index, flags, host request progress.
  logic [31:0] mem [int];
  bit m_run = 0, m_done = 0, m_err = 0;
  int ph = 0;      // 0 none, 1 requested not yet served, 2 ack cycle
  bit cool = 0;    // host_req must stay low for the cycle after the ack

  // 0 = RAM word, 1 = control word, 2 = misaligned or out of range
  function automatic int kind(logic [31:0] a);
    if (a == CTRL) return 1;
    if ((a % 4) != 0 || (a / 4) >= DEPTH) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] stat();
    return {30'b0, m_done, m_run};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    cexp_t ce;
    hexp_t he;
    if (mon_en) begin
      if (cpu_re && cq.size() > 0) begin
        ce = cq.pop_front();
        if (ce.chk) chk("cpu_rdata", cpu_rdata, ce.v);
      end
      chk("cpu_run", {31'b0, cpu_run}, {31'b0, m_run});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("err", {31'b0, err}, {31'b0, m_err});
      if (hq.size() > 0 && hq[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL host_ack_missing cyc=%0d got=none want=ack@%0d", cyc, hq[0].cyc);
        void'(hq.pop_front());
      end
      if (host_ack === 1'b1) begin
        if (hq.size() == 0 || hq[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL host_ack_unexpected cyc=%0d got=ack want=no_ack", cyc);
        end else begin
          he = hq.pop_front();
          total++;
          if (he.chk) chk("host_rdata", host_rdata, he.rd);
        end
      end else if (host_ack !== 1'b0) begin
        chk("host_ack_known", {31'b0, host_ack}, 32'd0);
      end
    end
  end

  // One clock of stimulus, with the model advanced by the spec's rules.
  task automatic step(bit we, bit re, logic [31:0] a, logic [31:0] d, bit rst_n);
    cexp_t ce;
    hexp_t he;
    bit go;
    int c0, ph_prev;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; reset = rst_n;
    if (re) begin
      ce.chk = 1; ce.v = '0;
      case (kind(a))
        0: if (mem.exists(int'(a / 4))) ce.v = mem[int'(a / 4)]; else ce.chk = 0;
        1: ce.v = stat();
        default: ce.v = '0;
      endcase
      cq.push_back(ce);
    end
    go = rst_n && (ph == 1) && !we && !re;
    c0 = cyc;
    ph_prev = ph;
    @(posedge clock);
    cool = 0;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_err = 0; ph = 0; host_req = 1'b0;
    end else begin
      if ((we || re) && kind(a) == 2) m_err = 1;
      if (we && kind(a) == 0) mem[int'(a / 4)] = d;
      if (we && kind(a) == 1 && d[1]) begin m_done = 1; m_run = 0; end
      if (go) begin
        he.cyc = c0 + 1; he.chk = !host_we; he.rd = '0;
        case (kind(host_addr))
          0: if (host_we) mem[int'(host_addr / 4)] = host_wdata;
             else if (mem.exists(int'(host_addr / 4))) he.rd = mem[int'(host_addr / 4)];
             else he.chk = 0;
          1: if (host_we) begin
               if (host_wdata[0]) begin m_run = 1; m_done = 0; end
               if (host_wdata[1]) m_done = 0;
             end else he.rd = stat();
          default: m_err = 1;
        endcase
        hq.push_back(he);
        ph = 2;
      end else if (ph_prev == 2) begin
        ph = 0; host_req = 1'b0; cool = 1;
      end
    end
    #1;
  endtask

  task automatic idle_until_free();
    int n = 0;
    while ((ph != 0 || cool) && n < 50) begin step(0, 0, '0, '0, 1); n++; end
  endtask

  task automatic host_issue(bit we, logic [31:0] a, logic [31:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; ph = 1;
  endtask

  task automatic host_do(bit we, logic [31:0] a, logic [31:0] d);
    idle_until_free();
    host_issue(we, a, d);
    idle_until_free();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      5:       return CTRL;
      6:       return ($urandom_range(0, 1) == 0) ? 32'h0000_0FFC : 32'h0000_1000;
      7:       return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      default: return 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset two cycles, then status word reads zero
    step(0, 0, '0, '0, 0);
    mon_en = 1;
    step(0, 0, '0, '0, 0);
    step(0, 1, CTRL, '0, 1);

    // 2: uncontended host write, then CPU load of the same word
    host_do(1, 32'h10, 32'hDEAD_BEEF);
    step(0, 1, 32'h10, '0, 1);

    // 3: host read waits behind three CPU stores, sees the stored value
    idle_until_free();
    host_issue(0, 32'h10, '0);
    repeat (3) step(1, 0, 32'h10, 32'h1234_5678, 1);
    idle_until_free();

    // 4: host starts the CPU, CPU signals done, host reads status
    host_do(1, CTRL, 32'h1);
    step(0, 1, CTRL, '0, 1);
    step(1, 0, CTRL, 32'h2, 1);
    host_do(0, CTRL, '0);

    // 5: misaligned CPU store and out-of-range host write
    step(1, 0, 32'h13, 32'hAAAA_AAAA, 1);
    host_do(1, 32'h1000, 32'h5555_5555);
    step(0, 1, 32'h10, '0, 1);
    step(0, 1, 32'h0FFC, '0, 1);
    host_do(0, 32'h1000, '0);
    repeat (3) step(0, 0, '0, '0, 1);

    // 6: reset while the host waits behind CPU loads
    idle_until_free();
    host_issue(0, 32'h10, '0);
    step(0, 1, 32'h20, '0, 1);
    step(0, 1, 32'h20, '0, 0);
    repeat (4) step(0, 0, '0, '0, 1);

    // random mix of CPU traffic, host traffic and occasional resets
    for (int i = 0; i < 800; i++) begin
      int r;
      if (ph == 0 && !cool && $urandom_range(0, 2) == 0)
        host_issue($urandom_range(0, 1) == 1, rand_addr(),
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      r = $urandom_range(0, 15);
      if (r < 5)       step(0, 0, '0, '0, 1);
      else if (r < 10) step(0, 1, rand_addr(), '0, 1);
      else if (r < 15) step(1, 0, rand_addr(),
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom, 1);
      else if (ph != 2 && $urandom_range(0, 3) == 0) step(0, 0, '0, '0, 0);
      else             step(0, 0, '0, '0, 1);
    end
    idle_until_free();
    repeat (3) step(0, 0, '0, '0, 1);
    if (hq.size() != 0) begin
      total++; bad++;
      $display("FAIL host_ack_pending got=%0d want=0", hq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
